// File: rtl/formula_stream_monitor.sv
// formula_stream_monitor
// In-order checker that sits beside a formula block. Every accepted argument
// is queued together with its expected result and issue timestamp. Each result
// is popped against the oldest entry, compared, and timed. Sticky error flags
// report unexpected results, mismatches, queue overflow and hung transactions.
// All outputs come straight from registers.

module formula_stream_monitor #(
    parameter int res_width = 32,
    parameter int depth     = 16,
    parameter int cnt_width = 16,
    parameter int timeout   = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arg_vld,
    input  logic [res_width-1:0]       exp,
    input  logic                       res_vld,
    input  logic [res_width-1:0]       res,
    output logic [$clog2(depth):0]     outstanding,
    output logic [cnt_width-1:0]       arg_cnt,
    output logic [cnt_width-1:0]       res_cnt,
    output logic [cnt_width-1:0]       lat_min,
    output logic [cnt_width-1:0]       lat_max,
    output logic                       err_unexpected,
    output logic                       err_mismatch,
    output logic                       err_overflow,
    output logic                       err_timeout,
    output logic [res_width-1:0]       first_exp,
    output logic [res_width-1:0]       first_act,
    output logic                       idle
);

    localparam int ptr_width = $clog2(depth);
    localparam int occ_width = ptr_width + 1;
    localparam logic [occ_width-1:0] depth_c   = occ_width'(depth);
    localparam logic [cnt_width-1:0] timeout_c = cnt_width'(timeout);

    logic [cnt_width-1:0] ts;
    logic [res_width-1:0] mem_exp [depth];
    logic [cnt_width-1:0] mem_ts  [depth];
    logic [ptr_width-1:0] wr_ptr;
    logic [ptr_width-1:0] rd_ptr;
    logic [occ_width-1:0] count_next;

    logic                 empty;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;
    logic [res_width-1:0] head_exp;
    logic [cnt_width-1:0] head_ts;
    logic [cnt_width-1:0] head_age;

    // Queue status, push/pop decisions and the age of the oldest entry.
    // A result in the same cycle as a push into an empty queue never pops.
    always_comb begin
        empty    = (outstanding == '0);
        full     = (outstanding == depth_c);
        do_pop   = res_vld && !empty;
        do_push  = arg_vld && (!full || do_pop);
        head_exp = mem_exp[rd_ptr];
        head_ts  = mem_ts[rd_ptr];
        head_age = ts - head_ts;
    end

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = outstanding;
        if (do_push && !do_pop) begin
            count_next = outstanding + occ_width'(1);
        end else if (do_pop && !do_push) begin
            count_next = outstanding - occ_width'(1);
        end
    end

    // Tracking storage; contents only matter between push and pop, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_exp[wr_ptr] <= exp;
            mem_ts[wr_ptr]  <= ts;
        end
    end

    // Timestamp, pointers, occupancy and the registered idle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            idle        <= 1'b1;
        end else begin
            ts          <= ts + cnt_width'(1);
            outstanding <= count_next;
            idle        <= (count_next == '0);
            if (do_push) begin
                wr_ptr <= wr_ptr + ptr_width'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_width'(1);
            end
        end
    end

    // Saturating argument/result counters and latency extremes.
    always_ff @(posedge clk) begin
        if (rst) begin
            arg_cnt <= '0;
            res_cnt <= '0;
            lat_min <= '1;
            lat_max <= '0;
        end else begin
            if (arg_vld && (arg_cnt != '1)) begin
                arg_cnt <= arg_cnt + cnt_width'(1);
            end
            if (res_vld && (res_cnt != '1)) begin
                res_cnt <= res_cnt + cnt_width'(1);
            end
            if (do_pop) begin
                if (head_age < lat_min) begin
                    lat_min <= head_age;
                end
                if (head_age > lat_max) begin
                    lat_max <= head_age;
                end
            end
        end
    end

    // Sticky error flags and capture of the first mismatching pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexpected <= 1'b0;
            err_mismatch   <= 1'b0;
            err_overflow   <= 1'b0;
            err_timeout    <= 1'b0;
            first_exp      <= '0;
            first_act      <= '0;
        end else begin
            if (res_vld && empty) begin
                err_unexpected <= 1'b1;
            end
            if (arg_vld && full && !do_pop) begin
                err_overflow <= 1'b1;
            end
            if (!empty && (head_age >= timeout_c)) begin
                err_timeout <= 1'b1;
            end
            if (do_pop && (res !== head_exp)) begin
                err_mismatch <= 1'b1;
                if (!err_mismatch) begin
                    first_exp <= head_exp;
                    first_act <= res;
                end
            end
        end
    end

endmodule

// File: doc/formula_stream_monitor.md
# formula_stream_monitor

Synthesizable in-order monitor for the formula pipe `arg_vld` / `res_vld` stream. It sits beside a formula block (pipelined or FSM-based) on FPGA or in simulation. It tracks every accepted argument until its result returns and compares each result against an expected value captured at issue time. It measures per-transaction latency and raises sticky error flags for unexpected results, data mismatches, tracking overflow and hangs.

## Interface

- `res_width`, 32, width of `exp` and `res`
- `depth`, 16, max outstanding transactions tracked (power of 2, ≥ 2)
- `cnt_width`, 16, width of counters, timestamps and latency values
- `timeout`, 1000, cycles the oldest outstanding transaction may wait before `err_timeout`
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `arg_vld`  in  1  argument issued to the formula block this cycle
- `exp`  in  res_width  expected result for the argument issued this cycle; valid with `arg_vld`
- `res_vld`  in  1  formula block output valid
- `res`  in  res_width  formula block result
- `outstanding`  out  $clog2(depth)+1  number of tracked, not yet returned transactions
- `arg_cnt`, `res_cnt`  out  cnt_width  accepted args / received results; both saturate
- `lat_min`, `lat_max`  out  cnt_width  min / max observed latency
- `err_unexpected`  out  1  sticky: result with nothing outstanding
- `err_mismatch`  out  1  sticky: `res` differed from queued expected value
- `err_overflow`  out  1  sticky: `arg_vld` while tracking queue full and no pop
- `err_timeout`  out  1  sticky: head transaction exceeded `timeout`
- `first_exp`, `first_act`  out  res_width  values of the first mismatch
- `idle`  out  1  `outstanding == 0`

## Operation

- Free-running timestamp `ts` (cnt_width) increments every non-reset cycle and wraps.
- Tracking queue: circular buffer of `depth` entries {exp, ts}, with write pointer, read pointer and an occupancy counter.
- Push on `arg_vld` stores {`exp`, `ts`}; `arg_cnt` += 1.
- Pop on `res_vld` when non-empty:
  - latency = `ts - head.ts` modulo 2^cnt_width
  - update `lat_min` / `lat_max`
  - `res_cnt` += 1
  - compare `res !== head.exp` (4-state compare in simulation); on mismatch set `err_mismatch`
  - if `err_mismatch` was previously clear, also capture `first_exp` / `first_act`
- Pointers wrap at `depth`.
- Boundary rules:
  - Empty + `res_vld`: set `err_unexpected`. No pop. `res_cnt` still increments.
  - Empty + `arg_vld` + `res_vld` in the same cycle: the result never matches a same-cycle argument (DUT latency ≥ 1). Set `err_unexpected`; the push proceeds.
  - Full + `arg_vld` + `res_vld`: pop and push both happen; occupancy unchanged; no error.
  - Full + `arg_vld` without `res_vld`: argument dropped, `err_overflow` set, `arg_cnt` still increments.
  - Counters saturate at all-ones. `lat_min`/`lat_max` never saturate (they are bounded by cnt_width).
  - Timeout: when non-empty and `ts - head.ts >= timeout`, set `err_timeout`.
- Error flags are sticky until `rst`.

## Timing

- All outputs are registered and reflect the inputs of the previous rising edge. Latency-0 combinational paths to outputs are not allowed.
- Reset values:
  - `ts`, pointers, `outstanding`, `arg_cnt`, `res_cnt`, `lat_max`: 0
  - `lat_min`: all-ones
  - all `err_*`: 0
  - `first_exp`, `first_act`: 0
  - `idle`: 1
- `rst` mid-operation discards all outstanding entries. Results arriving after reset for pre-reset args set `err_unexpected`.
- Measured latency equals the DUT's cycle distance between the `arg_vld` edge and the `res_vld` edge. A 1-cycle DUT reports 1.
- No backpressure: the monitor never stalls either stream.

## Test plan

- Single transaction: arg_vld with exp=3, res_vld with res=3 four cycles later -> `lat_min`=`lat_max`=4, `arg_cnt`=`res_cnt`=1, no errors, `idle`=1 one cycle after the result.
- Back-to-back stream: 16 args (exp=i) on consecutive cycles into a fixed 5-cycle pipe, results in order -> `outstanding` peaks at 5, `lat_min`=`lat_max`=5, no errors.
- Mismatch: expected 10 then 20, results 10 then 21 -> `err_mismatch`=1, `first_exp`=20, `first_act`=21. A later mismatch 7/8 does not change the captured pair.
- Overflow with depth=4:
  - 5 args with no result -> `err_overflow`=1, `outstanding`=4, `arg_cnt`=5
  - repeat with `res_vld` coincident on the 5th arg -> no overflow
- Unexpected result: `res_vld` with queue empty, both alone and coincident with `arg_vld` -> `err_unexpected`=1; in the coincident case `outstanding`=1 afterward.
- Timeout and reset: timeout=20, one arg with no result -> `err_timeout`=1 at the 20th cycle of waiting. Then `rst` for 3 cycles -> all outputs at reset values. A stale `res_vld` after reset -> `err_unexpected`=1.
